// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply/divide unit.
// Op encoding, FSM states, iteration count and divide-by-zero LO value.
package mips_muldiv_pkg;

    localparam int          MD_ITERATIONS = 32;
    localparam logic [31:0] MD_DIV0_LO    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } md_state_e;

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is
    // the correct unsigned magnitude.
    function automatic logic [31:0] md_mag(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? -x : x;
    endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
// Master drives the request; slave returns status and HI/LO.
interface mips_muldiv_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] register_a_data;
    logic [31:0] register_b_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, register_a_data, register_b_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, register_a_data, register_b_data,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit; MTHI/MTLO write HI/LO in one edge.
// Latency 34 edges accept-to-done-fall; start is ignored unless IDLE (no queuing).
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int ITERATIONS = MD_ITERATIONS
) (
    input  logic         clk,
    input  logic         reset,
    mips_muldiv_if.slave bus
);

    // Reset asserts asynchronously, releases two clock edges later.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        div_q, div_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    md_op_e      op;
    logic        op_signed;
    logic [31:0] a_mag, b_mag;
    logic        sign_diff;

    always_comb begin
        op        = md_op_e'(bus.op);
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_mag     = md_mag(bus.register_a_data, op_signed);
        b_mag     = md_mag(bus.register_b_data, op_signed);
        sign_diff = op_signed && (bus.register_a_data[31] ^ bus.register_b_data[31]);
    end

    // Single 33-bit adder: add for multiply, subtract (x + ~y + 1) for divide.
    // For divide the partial remainder is < 2*divisor, so bit 32 is a clean borrow.
    logic [32:0] add_x, add_y, add_r;

    always_comb begin
        add_x = div_q ? acc_q[63:31] : {1'b0, acc_q[63:32]};
        add_y = div_q ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
        add_r = add_x + add_y + {32'b0, div_q};
    end

    logic [31:0] quo_fix, rem_fix;
    logic [63:0] prod_fix;

    always_comb begin
        quo_fix  = neg_q_q ? -acc_q[31:0]  : acc_q[31:0];
        rem_fix  = neg_r_q ? -acc_q[63:32] : acc_q[63:32];
        prod_fix = neg_q_q ? -acc_q        : acc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            acc_d   = {32'b0, b_mag};
                            opnd_d  = a_mag;
                            div_d   = 1'b0;
                            neg_q_d = sign_diff;
                            neg_r_d = 1'b0;
                            dz_d    = 1'b0;
                            cnt_d   = 6'd0;
                            busy_d  = 1'b1;
                            state_d = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d   = {32'b0, a_mag};
                            opnd_d  = b_mag;
                            div_d   = 1'b1;
                            neg_q_d = sign_diff;
                            neg_r_d = op_signed && bus.register_a_data[31];
                            dz_d    = (bus.register_b_data == 32'd0);
                            cnt_d   = 6'd0;
                            busy_d  = 1'b1;
                            state_d = DIV;
                        end
                        OP_MTHI: hi_d = bus.register_a_data;
                        OP_MTLO: lo_d = bus.register_a_data;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = acc_q[0] ? {add_r, acc_q[31:1]}
                                 : {1'b0, acc_q[63:32], acc_q[31:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITERATIONS - 1)) state_d = FIXUP;
            end
            DIV: begin
                acc_d = add_r[32] ? {acc_q[62:0], 1'b0}
                                  : {add_r[31:0], acc_q[30:0], 1'b1};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITERATIONS - 1)) state_d = FIXUP;
            end
            FIXUP: begin
                if (div_q) begin
                    // Zero divisor leaves |a| as remainder; sign fixup restores rs exactly.
                    hi_d = rem_fix;
                    lo_d = dz_q ? MD_DIV0_LO : quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            div_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: latency, HI/LO results, MTHI/MTLO, ignored starts, reset abort.
module tb_mips_muldiv;
    import mips_muldiv_pkg::*;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mips_muldiv_if bus();

    mips_muldiv #(.ITERATIONS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one multiply/divide, optionally poke a second start at sample intr.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int intr);
        int busy_cnt = 0;
        int lat = 0;
        bit held = 1'b1;
        bus.start = 1'b1;
        bus.op = o;
        bus.register_a_data = a;
        bus.register_b_data = b;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.hi !== model_hi || bus.lo !== model_lo) held = 1'b0;
            bus.start = (i == intr);
            bus.op = OP_MULT;
            bus.register_a_data = 32'h0000_0009;
            bus.register_b_data = 32'h0000_0009;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'd34);
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
        chk({tag, " hilo_held"}, {31'd0, held}, 32'd1);
        chk({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " hi"}, bus.hi, exp_hi);
        chk({tag, " lo"}, bus.lo, exp_lo);
        model_hi = exp_hi;
        model_lo = exp_lo;
        @(negedge clk);
        chk({tag, " done_fall"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.register_a_data = 32'd0;
        bus.register_b_data = 32'd0;
        #3 reset = 1'b0;
        #1;
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst hi", bus.hi, 32'd0);
        chk("rst lo", bus.lo, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // MTHI then MTLO on consecutive edges
        bus.start = 1'b1;
        bus.op = OP_MTHI;
        bus.register_a_data = 32'h1234_5678;
        @(negedge clk);
        chk("mthi hi", bus.hi, 32'h1234_5678);
        chk("mthi lo", bus.lo, 32'd0);
        chk("mthi busy", {31'd0, bus.busy}, 32'd0);
        chk("mthi done", {31'd0, bus.done}, 32'd0);
        bus.op = OP_MTLO;
        bus.register_a_data = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo hi", bus.hi, 32'h1234_5678);
        chk("mtlo lo", bus.lo, 32'h9ABC_DEF0);
        chk("mtlo busy", {31'd0, bus.busy}, 32'd0);
        chk("mtlo done", {31'd0, bus.done}, 32'd0);
        model_hi = 32'h1234_5678;
        model_lo = 32'h9ABC_DEF0;

        run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu0", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 0);
        run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("div0neg", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        run_op("divu_busy_start", OP_DIVU, 32'd10, 32'd3, 32'h0000_0001, 32'h0000_0003, 5);

        // Undefined opcodes are ignored
        for (int u = 6; u <= 7; u++) begin
            bus.start = 1'b1;
            bus.op = 3'(u);
            bus.register_a_data = 32'hDEAD_BEEF;
            @(negedge clk);
            bus.start = 1'b0;
            chk("undef busy", {31'd0, bus.busy}, 32'd0);
            chk("undef hi", bus.hi, model_hi);
            chk("undef lo", bus.lo, model_lo);
        end

        // DIVU 10/3, second start at cycle 5, reset pulse at cycle 20
        bus.start = 1'b1;
        bus.op = OP_DIVU;
        bus.register_a_data = 32'd10;
        bus.register_b_data = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bad = 0;
        for (int i = 1; i <= 19; i++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            bus.start = (i == 5);
            bus.op = OP_MULT;
            bus.register_a_data = 32'h0000_0007;
            bus.register_b_data = 32'h0000_0007;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("abort busy_before", 32'(bad), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        chk("abort hi", bus.hi, 32'd0);
        chk("abort lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
            if (bus.hi !== 32'd0 || bus.lo !== 32'd0) bad++;
            @(negedge clk);
        end
        chk("abort quiet", 32'(bad), 32'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;

        run_op("post_reset_multu", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 SHALL provide: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: start  input  1  request strobe, sampled on rising clk.
REQ-004 SHALL provide: op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-005 SHALL provide: register_a_data  input  32  rs operand from the register file read port A.
REQ-006 SHALL provide: register_b_data  input  32  rt operand from the register file read port B.
REQ-007 SHALL provide: busy  output  1  high while an iterative operation is in progress.
REQ-008 SHALL provide: done  output  1  one-cycle pulse when HI/LO hold a new multiply/divide result.
REQ-009 SHALL provide: hi  output  32  HI register contents, driven continuously.
REQ-010 SHALL provide: lo  output  32  LO register contents, driven continuously.
REQ-011 SHALL have one parameter: ITERATIONS, default 32, number of shift steps; only 32 is supported.

Function
REQ-012 SHALL implement the FSM states IDLE, MUL, DIV, FIXUP, DONE.
REQ-013 In IDLE, start=1 with MULT/MULTU SHALL capture operands and move to MUL; with DIV/DIVU it SHALL move to DIV.
REQ-014 In IDLE, start=1 with MTHI SHALL load register_a_data into hi at that edge; MTLO SHALL load lo; both SHALL complete in one edge, leave busy and done low, and keep the FSM in IDLE.
REQ-015 start=1 with an undefined op SHALL be ignored.
REQ-016 start while busy=1 SHALL be ignored; operands SHALL NOT be re-sampled.
REQ-017 busy SHALL go high at the edge that accepts start and SHALL fall at the edge that enters DONE.
REQ-018 MUL SHALL run one shift-add step per cycle on operand magnitudes for exactly 32 cycles, then go to FIXUP.
REQ-019 DIV SHALL run one restoring step per cycle on operand magnitudes for exactly 32 cycles, then go to FIXUP.
REQ-020 The iteration counter SHALL be 6 bits, SHALL be cleared on accept, and SHALL exit on count 31.
REQ-021 FIXUP for signed MULT SHALL negate the 64-bit product when the operand signs differ.
REQ-022 FIXUP for signed DIV SHALL give the quotient the sign of a XOR b and the remainder the sign of a.
REQ-023 FIXUP SHALL write {hi,lo} as product[63:32], product[31:0]; for divide, lo=quotient and hi=remainder.
REQ-024 DONE SHALL hold done=1 for exactly one cycle, then return to IDLE; start is accepted again from that IDLE cycle.
REQ-025 Total latency SHALL be fixed at 34 edges from the accept edge to the edge at which done falls; hi/lo SHALL be valid while done=1.
REQ-026 Divide by zero SHALL take normal latency with no exception and give hi=dividend (the original rs value) and lo=0xFFFFFFFF, for both DIV and DIVU.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-028 hi and lo SHALL remain unchanged during MUL/DIV until the FIXUP edge, so reads of HI/LO (MFHI/MFLO) during busy return the old values.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for clk, force: FSM=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0.
REQ-030 Reset asserted mid-operation SHALL abort it with no partial result reaching hi/lo; deassertion SHALL be synchronised to clk.

Structure
REQ-031 Package mips_muldiv_pkg SHALL hold: the op encoding enum, the FSM state enum, the ITERATIONS constant, and the divide-by-zero LO constant.
REQ-032 The block SHALL be a single module with no sub-modules; the datapath SHALL use one shared 64-bit accumulator and one 33-bit adder/subtractor for both multiply and divide.

Verification
REQ-033 The bench SHALL cover MULT a=0xFFFFFFFD (-3), b=5 -> after 34 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 The bench SHALL cover MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high for all 33 cycles before DONE.
REQ-035 The bench SHALL cover DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 100/0 -> hi=0x00000064, lo=0xFFFFFFFF.
REQ-036 The bench SHALL cover MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive edges -> hi/lo updated one edge later each; busy and done stay 0.
REQ-037 The bench SHALL cover DIVU 10/3 started, a second start with MULT issued at cycle 5, and reset=0 pulsed at cycle 20 -> second start ignored; after reset hi=lo=0, busy=0, and no done pulse occurs.
REQ-038 The bench SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
